// File: rtl/myproject_mul_share_sched.sv
// Round-robin share of one signed multiplier among NUM_REQ requesters; result MUL_LATENCY ce-cycles after accept.
// Backpressure only on the request side (one grant per cycle, none while ce=0); results are never stalled.
module myproject_mul_share_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DIN_WIDTH   = 16,
  parameter int DOUT_WIDTH  = 26,
  parameter int MUL_LATENCY = 3,
  parameter int ID_WIDTH    = 2,
  parameter int CNT_WIDTH   = $clog2(MUL_LATENCY + 1)
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic                           ce,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DOUT_WIDTH-1:0]          rsp_dout,
  output logic [CNT_WIDTH-1:0]           inflight,
  output logic                           idle
);

  typedef struct packed {
    logic                  vld;
    logic [ID_WIDTH-1:0]   id;
    logic [DOUT_WIDTH-1:0] dat;
  } ent_t;

  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  gnt_idx;
  logic                 xfer;
  logic [DIN_WIDTH-1:0] sel_a;
  logic [DIN_WIDTH-1:0] sel_b;

  // Two passes: requesters at or above rr_ptr first, then the wrapped-around ones.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    xfer      = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ce && !xfer && req_valid[i] && (ID_WIDTH'(i) >= rr_ptr)) begin
        xfer         = 1'b1;
        gnt_idx      = ID_WIDTH'(i);
        req_ready[i] = 1'b1;
        sel_a        = req_a[i*DIN_WIDTH +: DIN_WIDTH];
        sel_b        = req_b[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ce && !xfer && req_valid[i]) begin
        xfer         = 1'b1;
        gnt_idx      = ID_WIDTH'(i);
        req_ready[i] = 1'b1;
        sel_a        = req_a[i*DIN_WIDTH +: DIN_WIDTH];
        sel_b        = req_b[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (ce && xfer) begin
      rr_ptr <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
    end
  end

  logic                        s1_vld;
  logic [ID_WIDTH-1:0]         s1_id;
  logic signed [DIN_WIDTH-1:0] s1_a;
  logic signed [DIN_WIDTH-1:0] s1_b;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (ce) begin
      s1_vld <= xfer;
      if (xfer) begin
        s1_id <= gnt_idx;
        s1_a  <= sel_a;
        s1_b  <= sel_b;
      end
    end
  end

  // Low DOUT_WIDTH bits of the product equal those of the sign-extended operands' product.
  logic signed [DOUT_WIDTH-1:0] ext_a;
  logic signed [DOUT_WIDTH-1:0] ext_b;
  logic signed [DOUT_WIDTH-1:0] s1_res;
  assign ext_a  = DOUT_WIDTH'(s1_a);
  assign ext_b  = DOUT_WIDTH'(s1_b);
  assign s1_res = ext_a * ext_b;

  logic                  out_vld;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DOUT_WIDTH-1:0] out_dat;

  if (MUL_LATENCY == 1) begin : g_lat1
    assign out_vld = s1_vld;
    assign out_id  = s1_id;
    assign out_dat = s1_res;
  end else begin : g_pipe
    ent_t pipe [MUL_LATENCY-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int k = 0; k < MUL_LATENCY - 1; k++) pipe[k] <= '0;
      end else if (ce) begin
        pipe[0].vld <= s1_vld;
        if (s1_vld) begin
          pipe[0].id  <= s1_id;
          pipe[0].dat <= s1_res;
        end
        for (int k = 1; k < MUL_LATENCY - 1; k++) begin
          pipe[k].vld <= pipe[k-1].vld;
          if (pipe[k-1].vld) begin
            pipe[k].id  <= pipe[k-1].id;
            pipe[k].dat <= pipe[k-1].dat;
          end
        end
      end
    end

    assign out_vld = pipe[MUL_LATENCY-2].vld;
    assign out_id  = pipe[MUL_LATENCY-2].id;
    assign out_dat = pipe[MUL_LATENCY-2].dat;
  end

  // Gating with ce keeps a result visible only in the cycle it actually drains.
  assign rsp_valid = out_vld & ce;
  assign rsp_id    = out_id;
  assign rsp_dout  = out_dat;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      inflight <= '0;
    end else if (ce) begin
      if (xfer && !out_vld) begin
        inflight <= inflight + CNT_WIDTH'(1);
      end else if (!xfer && out_vld) begin
        inflight <= inflight - CNT_WIDTH'(1);
      end
    end
  end

  assign idle = (inflight == '0) && (req_valid == '0);

endmodule

// File: tb/tb_myproject_mul_share_sched.sv
// Bench for the shared-multiplier scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized requester/ce phase.
module tb_myproject_mul_share_sched;
  localparam int L = 3;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ce;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [25:0] rsp_dout;
  logic [1:0]  inflight;
  logic        idle;

  myproject_mul_share_sched #(
    .NUM_REQ(4), .DIN_WIDTH(16), .DOUT_WIDTH(26), .MUL_LATENCY(L), .ID_WIDTH(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dout(rsp_dout),
    .inflight(inflight), .idle(idle)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted operations, each aging by one per ce=1 edge.
  typedef struct {
    int          id;
    logic [25:0] dat;
    int          age;
  } ment_t;

  ment_t mq[$];
  ment_t me;
  int    m_rr   = 0;
  int    last_g = -1;
  int    cg;
  logic  cev;
  logic [3:0] cready;

  function automatic int mgrant();
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_rr + k) % 4;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [25:0] mprod(input int g);
    longint a, b, p;
    a = longint'($signed(req_a[g*16 +: 16]));
    b = longint'($signed(req_b[g*16 +: 16]));
    p = a * b;
    return p[25:0];
  endfunction

  initial begin
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        mq.delete();
        m_rr   = 0;
        last_g = -1;
      end else begin
        cg     = mgrant();
        cready = (ce && cg >= 0) ? (4'b0001 << cg) : 4'b0000;
        cev    = ce && (mq.size() > 0) && (mq[0].age == L);
        chk("req_ready", req_ready, cready);
        chk("rsp_valid", rsp_valid, cev);
        if (cev) begin
          chk("rsp_id", rsp_id, mq[0].id);
          chk("rsp_dout", rsp_dout, mq[0].dat);
        end
        chk("inflight", inflight, mq.size());
        chk("idle", idle, (mq.size() == 0) && (req_valid == 4'b0));
        if (ce) begin
          if (cev) void'(mq.pop_front());
          foreach (mq[k]) mq[k].age++;
          if (cg >= 0) begin
            me.id  = cg;
            me.dat = mprod(cg);
            me.age = 1;
            mq.push_back(me);
            m_rr = (cg + 1) % 4;
          end
          last_g = cg;
        end else begin
          last_g = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (inflight != 2'd0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", inflight, 0);
  endtask

  task automatic single(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [25:0] exp);
    logic found;
    tick();
    req_valid = 4'b0100;
    req_a[32 +: 16] = a;
    req_b[32 +: 16] = b;
    tick();
    req_valid = 4'b0000;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge ap_clk);
      if (rsp_valid) begin
        found = 1'b1;
        chk(name, rsp_dout, exp);
      end
    end
    chk({name, "_seen"}, found, 1'b1);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [3:0] pend;

  initial begin
    ap_rst_n  = 1'b0;
    ce        = 1'b1;
    req_valid = 4'b0;
    req_a     = '0;
    req_b     = '0;
    pend      = 4'b0;

    repeat (2) @(negedge ap_clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_dout", rsp_dout, 0);
    chk("rst_idle", idle, 1);
    tick();
    ap_rst_n = 1'b1;
    tick();

    // All four held valid: strict rotation, results in the same order three cycles later.
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(i + 1);
      req_b[i*16 +: 16] = 16'(-(i + 7));
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      chk("t2_grant", req_ready, 4'b0001 << (k % 4));
      if (k >= 3) begin
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_id", rsp_id, (k - 3) % 4);
      end
      tick();
    end
    req_valid = 4'b0;
    drain();

    // 3 * -5 = -15, truncated to 26 bits.
    tick();
    req_valid = 4'b0001;
    req_a[0 +: 16] = 16'd3;
    req_b[0 +: 16] = 16'hFFFB;
    @(negedge ap_clk);
    chk("t1_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0;
    @(negedge ap_clk);
    chk("t1_early1", rsp_valid, 0);
    tick();
    @(negedge ap_clk);
    chk("t1_early2", rsp_valid, 0);
    tick();
    @(negedge ap_clk);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_dout", rsp_dout, 26'h3FFFFF1);
    drain();

    // Move rr_ptr to 2, then 4'b1010 must grant 3 before 1.
    tick();
    req_valid = 4'b0010;
    @(negedge ap_clk);
    chk("t3_setup", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    @(negedge ap_clk);
    chk("t3_first", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0010;
    @(negedge ap_clk);
    chk("t3_second", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    @(negedge ap_clk);
    chk("t3_rr_is_2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0;
    drain();

    single("t4_min_sq", 16'h8000, 16'h8000, 26'd0);
    single("t4_max_x2", 16'h7FFF, 16'd2, 26'd65534);
    drain();

    // Back-to-back stream with a five-cycle ce stall in the middle.
    tick();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = rnd16();
      req_b[i*16 +: 16] = rnd16();
    end
    req_valid = 4'b1111;
    repeat (6) tick();
    @(negedge ap_clk);
    chk("t5_full", inflight, 3);
    tick();
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk("t5_stall_ready", req_ready, 0);
      chk("t5_stall_valid", rsp_valid, 0);
      chk("t5_stall_inflight", inflight, 3);
      tick();
    end
    ce = 1'b1;
    repeat (4) tick();
    req_valid = 4'b0;
    drain();

    // Reset with a full pipe: everything in flight is discarded.
    tick();
    req_valid = 4'b1111;
    repeat (3) tick();
    @(negedge ap_clk);
    chk("t6_pre", inflight, 3);
    tick();
    req_valid = 4'b0;
    ap_rst_n  = 1'b0;
    #1;
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_inflight", inflight, 0);
    chk("t6_idle", idle, 1);
    tick();
    tick();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      chk("t6_no_stale", rsp_valid, 0);
      tick();
    end
    req_valid = 4'b1001;
    @(negedge ap_clk);
    chk("t6_rr_zero", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1000;
    @(negedge ap_clk);
    chk("t6_next", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0;
    drain();

    // Random requesters honouring hold-until-transfer, random ce.
    pend = 4'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (last_g >= 0) pend[last_g] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          req_a[i*16 +: 16] = rnd16();
          req_b[i*16 +: 16] = rnd16();
        end
      end
      req_valid = pend;
      ce = ($urandom_range(0, 7) != 0);
    end
    tick();
    ce        = 1'b1;
    req_valid = 4'b0;
    drain();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
